rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register data width in bits (>=1).
REQ-002 SHALL provide parameter NUM_REGS, default 8, number of registers (2..64, need not be a power of two).
REQ-003 SHALL provide derived localparam SEL_W = ceil(log2(NUM_REGS)), the width of every select port.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- read1regsel  input  SEL_W  read port 1 register select.
- read2regsel  input  SEL_W  read port 2 register select.
- writeregsel  input  SEL_W  write register select.
- writedata  input  DATA_W  write data.
- write  input  1  write enable.
- rsvregsel  input  SEL_W  reserve register select.
- reserve  input  1  reserve request; marks the register busy (pending producer).
- read1data  output  DATA_W  read port 1 data.
- read2data  output  DATA_W  read port 2 data.
- read1busy  output  1  register selected by read1regsel is busy.
- read2busy  output  1  register selected by read2regsel is busy.
- err  output  1  protocol/range error this cycle.

Function
REQ-005 Read data and busy outputs SHALL be combinational from current state and select inputs, with zero-cycle latency.
REQ-006 When write=1 and writeregsel<NUM_REGS, the selected register SHALL load writedata and clear its busy bit on the next rising clk.
REQ-007 When reserve=1 and rsvregsel<NUM_REGS, the selected register's busy bit SHALL be set on the next rising clk.
REQ-008 If write and reserve target the same register in the same cycle, the data SHALL update and the busy bit SHALL end up 1 (reserve wins).
REQ-009 Each busy bit SHALL be a 2-state machine: IDLE->BUSY on reserve; BUSY->IDLE on a write without a same-register reserve; otherwise hold.
REQ-010 A read select >= NUM_REGS SHALL return data 0 and busy 0.
REQ-011 A write or reserve with select >= NUM_REGS SHALL change no state.
REQ-012 err SHALL be combinational and SHALL be 1 exactly when any of the following holds:
- reserve=1 and the target is already BUSY and not written in the same cycle;
- write=1 with writeregsel >= NUM_REGS;
- reserve=1 with rsvregsel >= NUM_REGS;
- either read select >= NUM_REGS.
REQ-013 Both read ports SHALL be fully independent and MAY select the same register.

Reset
REQ-014 While rst=1, all registers SHALL be 0 and all busy bits IDLE, regardless of clk.
REQ-015 Reset asserted mid-operation SHALL discard any same-cycle write or reserve.
REQ-016 After reset, read*data=0, read*busy=0, and err=0 for in-range selects with write=reserve=0.

Configuration
REQ-017 With RF_BYPASS_EN defined, a read port whose select equals writeregsel while write=1 (in range) SHALL output writedata and busy 0 in the same cycle.
REQ-018 Without RF_BYPASS_EN, read ports SHALL show only stored state; a write becomes visible the cycle after the clock edge.

Structure
REQ-019 Package rf_pkg SHALL hold the DATA_W/NUM_REGS defaults and the busy-state enumeration (IDLE, BUSY).
REQ-020 Storage SHALL use one sub-module, reg_nbit: a DATA_W-wide register with enable and async active-high reset, instantiated NUM_REGS times via generate.

Verification
REQ-021 Reset, then read regs 0 and 7 -> data 0x0000, busy 0, err 0.
REQ-022 Write 0xBEEF to r3, then read r3 on both ports next cycle -> 0xBEEF on both; with RF_BYPASS_EN, 0xBEEF also in the write cycle.
REQ-023 Reserve r5, then write 0x1234 to r5 -> read2busy=1 for one cycle, then 0 with data 0x1234.
REQ-024 Reserve r2 twice in consecutive cycles -> err=1 in the second cycle only; then write and reserve r2 in the same cycle -> err=0 and busy stays 1.
REQ-025 With NUM_REGS=6, write to 7 and read 6 -> err=1, read data 0, and no register changes.
REQ-026 Assert rst between clock edges during a pending write to r1 -> r1 reads 0 and busy is 0 immediately and after the next edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and busy-state encoding for the register-file scoreboard.
package rf_pkg;
  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busy_e;
endpackage

// File: rtl/rf_scoreboard_if.sv
// Register-file scoreboard bus: read/write/reserve selects in, read data/busy/err out.
interface rf_scoreboard_if
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic [SEL_W-1:0]  read1regsel;
  logic [SEL_W-1:0]  read2regsel;
  logic [SEL_W-1:0]  writeregsel;
  logic [SEL_W-1:0]  rsvregsel;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              reserve;
  logic [DATA_W-1:0] read1data;
  logic [DATA_W-1:0] read2data;
  logic              read1busy;
  logic              read2busy;
  logic              err;

  modport master (
    output read1regsel, read2regsel, writeregsel, rsvregsel, writedata, write, reserve,
    input  read1data, read2data, read1busy, read2busy, err
  );

  modport slave (
    input  read1regsel, read2regsel, writeregsel, rsvregsel, writedata, write, reserve,
    output read1data, read2data, read1busy, read2busy, err
  );
endinterface

// File: rtl/rf_scoreboard_reg_nbit.sv
// DATA_W-wide storage register with load enable and async active-high reset.
module reg_nbit
  import rf_pkg::*;
#(
  parameter int W = RF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
    end else if (en_i) begin
      dat_q <= d_i;
    end
  end

  assign q_o = dat_q;
endmodule

// File: rtl/rf_scoreboard.sv
// Register file with per-register busy (pending producer) tracking; reads and err are combinational.
// Optional RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input logic            clk,
  input logic            rst,
  rf_scoreboard_if.slave sb
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  // Lookup tables span the full select range; unpopulated slots read as zero/idle.
  logic [DATA_W-1:0] reg_dat [DEPTH];
  logic [DEPTH-1:0]  busy_vec;

  logic rd1_in, rd2_in, wr_in, rsv_in;
  logic wr_ok, rsv_ok;

  assign rd1_in = ({1'b0, sb.read1regsel} < NREGS);
  assign rd2_in = ({1'b0, sb.read2regsel} < NREGS);
  assign wr_in  = ({1'b0, sb.writeregsel} < NREGS);
  assign rsv_in = ({1'b0, sb.rsvregsel}   < NREGS);
  assign wr_ok  = sb.write   && wr_in;
  assign rsv_ok = sb.reserve && rsv_in;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic  wr_hit, rsv_hit;
    busy_e busy_q, busy_d;

    assign wr_hit  = wr_ok  && (sb.writeregsel == SEL_W'(i));
    assign rsv_hit = rsv_ok && (sb.rsvregsel   == SEL_W'(i));

    reg_nbit #(.W(DATA_W)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (wr_hit),
      .d_i  (sb.writedata),
      .q_o  (reg_dat[i])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_q <= IDLE;
      end else begin
        busy_q <= busy_d;
      end
    end

    // A reserve landing with a write to the same register leaves it BUSY.
    always_comb begin
      busy_d = busy_q;
      case (busy_q)
        IDLE: if (rsv_hit)            busy_d = BUSY;
        BUSY: if (wr_hit && !rsv_hit) busy_d = IDLE;
      endcase
    end

    assign busy_vec[i] = (busy_q == BUSY);
  end

  for (genvar i = NUM_REGS; i < DEPTH; i++) begin : g_pad
    assign reg_dat[i]  = '0;
    assign busy_vec[i] = 1'b0;
  end

  logic [DATA_W-1:0] rd1_dat, rd2_dat;
  logic              rd1_busy, rd2_busy;

  always_comb begin
    rd1_dat  = reg_dat[sb.read1regsel];
    rd2_dat  = reg_dat[sb.read2regsel];
    rd1_busy = busy_vec[sb.read1regsel];
    rd2_busy = busy_vec[sb.read2regsel];
`ifdef RF_BYPASS_EN
    if (wr_ok && !rst && (sb.read1regsel == sb.writeregsel)) begin
      rd1_dat  = sb.writedata;
      rd1_busy = 1'b0;
    end
    if (wr_ok && !rst && (sb.read2regsel == sb.writeregsel)) begin
      rd2_dat  = sb.writedata;
      rd2_busy = 1'b0;
    end
`endif
  end

  logic rsv_conflict;

  assign rsv_conflict = rsv_ok && busy_vec[sb.rsvregsel]
                        && !(wr_ok && (sb.writeregsel == sb.rsvregsel));

  assign sb.read1data = rd1_dat;
  assign sb.read2data = rd2_dat;
  assign sb.read1busy = rd1_busy;
  assign sb.read2busy = rd2_busy;
  assign sb.err       = rsv_conflict
                        || (sb.write   && !wr_in)
                        || (sb.reserve && !rsv_in)
                        || !rd1_in || !rd2_in;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized scoreboard bench driving an 8-register and a 6-register instance in lockstep.
module tb_rf_scoreboard;
  localparam int DW = 16;
  localparam int SW = 3;

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          b1;
    logic          b2;
    logic          e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SW-1:0] s1, s2, ws, rs;
  logic [DW-1:0] wd;
  logic          w, r;

  rf_scoreboard_if #(.DATA_W(DW), .NUM_REGS(8)) if8 ();
  rf_scoreboard_if #(.DATA_W(DW), .NUM_REGS(6)) if6 ();

  assign if8.read1regsel = s1;
  assign if8.read2regsel = s2;
  assign if8.writeregsel = ws;
  assign if8.rsvregsel   = rs;
  assign if8.writedata   = wd;
  assign if8.write       = w;
  assign if8.reserve     = r;
  assign if6.read1regsel = s1;
  assign if6.read2regsel = s2;
  assign if6.writeregsel = ws;
  assign if6.rsvregsel   = rs;
  assign if6.writedata   = wd;
  assign if6.write       = w;
  assign if6.reserve     = r;

  rf_scoreboard #(.DATA_W(DW), .NUM_REGS(8)) dut8 (.clk(clk), .rst(rst), .sb(if8));
  rf_scoreboard #(.DATA_W(DW), .NUM_REGS(6)) dut6 (.clk(clk), .rst(rst), .sb(if6));

  exp_t act [2];
  assign act[0] = {if8.read1data, if8.read2data, if8.read1busy, if8.read2busy, if8.err};
  assign act[1] = {if6.read1data, if6.read2data, if6.read1busy, if6.read2busy, if6.err};

  // Reference state: plain register contents and busy flags per instance.
  logic [DW-1:0] md [2][8];
  bit            mb [2][8];
  int            nr [2];
  exp_t          q  [2][$];
  int            checks   = 0;
  int            failures = 0;

  function automatic bit inr(input int d, input logic [SW-1:0] s);
    return int'(s) < nr[d];
  endfunction

  function automatic exp_t expect_out(input int d, input bit in_rst);
    exp_t e;
    e.d1 = inr(d, s1) ? md[d][s1] : '0;
    e.d2 = inr(d, s2) ? md[d][s2] : '0;
    e.b1 = inr(d, s1) ? mb[d][s1] : 1'b0;
    e.b2 = inr(d, s2) ? mb[d][s2] : 1'b0;
`ifdef RF_BYPASS_EN
    if (!in_rst && w && inr(d, ws) && s1 == ws) begin e.d1 = wd; e.b1 = 1'b0; end
    if (!in_rst && w && inr(d, ws) && s2 == ws) begin e.d2 = wd; e.b2 = 1'b0; end
`endif
    e.e = 1'b0;
    if (!inr(d, s1) || !inr(d, s2)) e.e = 1'b1;
    if (w && !inr(d, ws))           e.e = 1'b1;
    if (r && !inr(d, rs))           e.e = 1'b1;
    if (r && inr(d, rs) && mb[d][rs] && !(w && ws == rs)) e.e = 1'b1;
    if (in_rst) e.e = e.e;
    return e;
  endfunction

  task automatic apply_edge(input int d);
    if (w && inr(d, ws)) begin
      md[d][ws] = wd;
      mb[d][ws] = 1'b0;
    end
    if (r && inr(d, rs)) mb[d][rs] = 1'b1;
  endtask

  task automatic step(input bit iw, input logic [SW-1:0] iws, input logic [DW-1:0] iwd,
                      input bit ir, input logic [SW-1:0] irs,
                      input logic [SW-1:0] is1, input logic [SW-1:0] is2, input bit rst_mid);
    @(posedge clk);
    #1;
    rst = 1'b0;
    w = iw; ws = iws; wd = iwd; r = ir; rs = irs; s1 = is1; s2 = is2;
    #2;
    if (rst_mid) rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst_mid) begin
        for (int k = 0; k < 8; k++) begin
          md[d][k] = '0;
          mb[d][k] = 1'b0;
        end
      end
      q[d].push_back(expect_out(d, rst_mid));
      if (!rst_mid) apply_edge(d);
    end
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h at %0t", nm, d, a, x, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (q[d].size() != 0) begin
          e = q[d].pop_front();
          chk("read1data", d, 32'(act[d].d1), 32'(e.d1));
          chk("read2data", d, 32'(act[d].d2), 32'(e.d2));
          chk("read1busy", d, 32'(act[d].b1), 32'(e.b1));
          chk("read2busy", d, 32'(act[d].b2), 32'(e.b2));
          chk("err",       d, 32'(act[d].e),  32'(e.e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    logic [SW-1:0] a, b;
    nr[0] = 8;
    nr[1] = 6;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        md[d][k] = '0;
        mb[d][k] = 1'b0;
      end
    w = 0; r = 0; ws = 0; rs = 0; wd = '0; s1 = 0; s2 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Post-reset reads of r0 and r7.
    step(0, 0, 16'h0000, 0, 0, 0, 7, 0);
    // Write then read r3 on both ports.
    step(1, 3, 16'hBEEF, 0, 0, 3, 3, 0);
    step(0, 0, 16'h0000, 0, 0, 3, 3, 0);
    // Reserve r5, then write it.
    step(0, 0, 16'h0000, 1, 5, 0, 5, 0);
    step(1, 5, 16'h1234, 0, 0, 0, 5, 0);
    step(0, 0, 16'h0000, 0, 0, 5, 5, 0);
    // Double reserve of r2, then write+reserve in one cycle.
    step(0, 0, 16'h0000, 1, 2, 2, 2, 0);
    step(0, 0, 16'h0000, 1, 2, 2, 2, 0);
    step(1, 2, 16'h5A5A, 1, 2, 2, 2, 0);
    step(0, 0, 16'h0000, 0, 0, 2, 2, 0);
    // Out-of-range write/read on the 6-register instance.
    step(1, 7, 16'hDEAD, 0, 0, 6, 0, 0);
    step(0, 0, 16'h0000, 1, 6, 3, 5, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 16'h0000, 0, 0, SW'(k), SW'(5 - k), 0);
    // Reset arriving between edges while a write to r1 is pending.
    step(1, 1, 16'hA5A5, 1, 4, 1, 4, 0);
    step(1, 1, 16'h7777, 0, 0, 1, 1, 1);
    step(0, 0, 16'h0000, 0, 0, 1, 4, 0);

    for (int n = 0; n < 400; n++) begin
      a = SW'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? a : SW'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), DW'($urandom),
           ($urandom_range(0, 2) == 0), SW'($urandom_range(0, 7)), a, b,
           ($urandom_range(0, 99) == 0));
    end

    repeat (3) @(posedge clk);
    for (int d = 0; d < 2; d++) chk("queue_drain", d, 32'(q[d].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
